// File: rtl/button_debouncer.sv
// Push-button conditioner: two-flop synchronizer, tick-paced debounce FSM, and
// registered rise/fall pulses. Define BUTTON_DEBOUNCER_HOLD_EN to add the long-hold pulse.
module button_debouncer #(
    parameter int DB_TICKS   = 20,
    parameter int HOLD_TICKS = 1000,
    parameter int CNT_W      = 11
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_rise,
    output logic btn_fall,
    output logic btn_hold
);

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'd0,
        PEND_HIGH   = 2'd1,
        STABLE_HIGH = 2'd2,
        PEND_LOW    = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_TICKS - 1);

    // Counters must be able to reach their terminal values without wrapping.
    if (DB_TICKS < 1 || HOLD_TICKS < 1 ||
        (2 ** CNT_W) <= DB_TICKS || (2 ** CNT_W) <= HOLD_TICKS) begin : g_bad_params
        $error("button_debouncer: illegal DB_TICKS/HOLD_TICKS/CNT_W combination");
    end

    logic             s1_q, s2_q;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= btn_raw;
            s2_q <= s1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= STABLE_LOW;
            db_cnt_q <= '0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            db_cnt_q <= db_cnt_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
        end
    end

    // Any sample agreeing with the current level abandons the pending flip.
    always_comb begin
        state_d  = state_q;
        db_cnt_d = db_cnt_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        unique case (state_q)
            STABLE_LOW: begin
                if (s2_q) begin
                    state_d  = PEND_HIGH;
                    db_cnt_d = '0;
                end
            end
            PEND_HIGH: begin
                if (!s2_q) begin
                    state_d  = STABLE_LOW;
                    db_cnt_d = '0;
                end else if (tick) begin
                    if (db_cnt_q == DB_LAST) begin
                        state_d  = STABLE_HIGH;
                        db_cnt_d = '0;
                        rise_d   = 1'b1;
                    end else begin
                        db_cnt_d = db_cnt_q + CNT_W'(1);
                    end
                end
            end
            STABLE_HIGH: begin
                if (!s2_q) begin
                    state_d  = PEND_LOW;
                    db_cnt_d = '0;
                end
            end
            PEND_LOW: begin
                if (s2_q) begin
                    state_d  = STABLE_HIGH;
                    db_cnt_d = '0;
                end else if (tick) begin
                    if (db_cnt_q == DB_LAST) begin
                        state_d  = STABLE_LOW;
                        db_cnt_d = '0;
                        fall_d   = 1'b1;
                    end else begin
                        db_cnt_d = db_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d  = STABLE_LOW;
                db_cnt_d = '0;
            end
        endcase
    end

    assign btn_level = (state_q == STABLE_HIGH) || (state_q == PEND_LOW);
    assign btn_rise  = rise_q;
    assign btn_fall  = fall_q;

`ifdef BUTTON_DEBOUNCER_HOLD_EN
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_TICKS - 1);
    localparam logic [CNT_W-1:0] HOLD_SAT  = CNT_W'(HOLD_TICKS);

    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             hold_q, hold_d;

    // Held at zero outside STABLE_HIGH, so every entry restarts the count;
    // parking at HOLD_TICKS makes the pulse fire once per stay.
    always_comb begin
        hold_cnt_d = hold_cnt_q;
        hold_d     = 1'b0;
        if (state_q != STABLE_HIGH) begin
            hold_cnt_d = '0;
        end else if (tick && hold_cnt_q == HOLD_LAST) begin
            hold_d     = 1'b1;
            hold_cnt_d = HOLD_SAT;
        end else if (tick && hold_cnt_q < HOLD_LAST) begin
            hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_cnt_q <= '0;
            hold_q     <= 1'b0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
            hold_q     <= hold_d;
        end
    end

    assign btn_hold = hold_q;
`else
    assign btn_hold = 1'b0;
`endif

endmodule

// File: doc/button_debouncer.md
# button_debouncer

Conditions a raw, asynchronous push-button input for the reaction-timer controller. It synchronizes the input with a two-flop chain and debounces it against a slow tick-enable strobe. It then produces a clean level plus single-cycle rise, fall and (optionally) long-hold pulses. It sits between the board pin and the reaction-timer FSM, which consumes only the pulses and the level.

## Interface
- DB_TICKS, 20: consecutive ticks the synchronized input must differ from the current level before the level flips (≥1).
- HOLD_TICKS, 1000: ticks of continuous stable-high before btn_hold fires (≥1; used only with hold feature).
- CNT_W, 11: counter width; must satisfy 2^CNT_W > max(DB_TICKS, HOLD_TICKS).
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- tick  input  1  one-clk strobe (e.g. 1 kHz) that advances debounce/hold counters; the only count enable.
- btn_raw  input  1  asynchronous button pin, active-high.
- btn_level  output  1  debounced button level.
- btn_rise  output  1  one-clk pulse when btn_level goes 0→1.
- btn_fall  output  1  one-clk pulse when btn_level goes 1→0.
- btn_hold  output  1  one-clk pulse, once per press, after HOLD_TICKS of stable high.

## Operation
- Sync: s1 <= btn_raw; s2 <= s1. Only s2 is used downstream.
- FSM states: STABLE_LOW, PEND_HIGH, STABLE_HIGH, PEND_LOW. Reset state STABLE_LOW.
- STABLE_LOW: s2=1 → PEND_HIGH, db_cnt<=0.
- PEND_HIGH: s2=0 → STABLE_LOW, db_cnt<=0 (bounce discards progress). s2=1 & tick & db_cnt==DB_TICKS-1 → STABLE_HIGH, btn_level<=1, btn_rise<=1, db_cnt<=0. s2=1 & tick otherwise → db_cnt+1. No tick → hold.
- STABLE_HIGH / PEND_LOW: mirror of the above with polarities swapped; the flip to STABLE_LOW sets btn_level<=0, btn_fall<=1.
- btn_level is 1 exactly in STABLE_HIGH and PEND_LOW.
- Pulses are registered, high for exactly one clk, cleared on the next edge.
- At most one of btn_rise/btn_fall/btn_hold is high in any cycle.
- db_cnt never exceeds DB_TICKS-1; counters never wrap.

## Timing
- Reset: s1=s2=0, state STABLE_LOW, db_cnt=0, hold_cnt=0. Outputs btn_level=0, btn_rise=0, btn_fall=0, btn_hold=0.
- Reset asserted mid-press: level drops to 0 at the reset edge with no btn_fall pulse. After release of reset, a still-pressed button needs full sync + DB_TICKS ticks to produce btn_rise.
- Latency, clean edge: 2 clk for sync, +1 clk to enter PEND, then DB_TICKS tick cycles. Level and pulse update on the edge of the DB_TICKS-th qualifying tick.
- DB_TICKS=1: the flip occurs on the first tick seen while in PEND.
- A tick coinciding with s2 returning to the stable value counts nothing; the state returns to STABLE.
- tick held high continuously is legal: counting proceeds every clk.

## Configuration
- Macro BUTTON_DEBOUNCER_HOLD_EN.
- Defined: hold_cnt (CNT_W bits) clears on entry to STABLE_HIGH and increments on tick while in STABLE_HIGH (not PEND_LOW). On the tick where hold_cnt==HOLD_TICKS-1, btn_hold pulses once and hold_cnt saturates until the state leaves STABLE_HIGH. A bounce into PEND_LOW and back to STABLE_HIGH restarts hold counting.
- Not defined: no hold counter is instantiated; btn_hold is constant 0; all other behaviour is identical.

## Test plan
- Use DB_TICKS=4, HOLD_TICKS=8, tick every 4th clk, macro defined.
- Reset with btn_raw=1 held → all outputs 0 during reset. After release, btn_rise fires exactly once, on the 4th tick after s2=1, and btn_level=1 from that edge.
- Bounce: btn_raw high for 2 ticks, low for 1, then high steadily → no pulse until 4 consecutive high ticks, then a single btn_rise.
- Release after stable press → btn_fall one clk wide on the 4th low tick; btn_level=0 the same edge; no btn_rise/btn_hold.
- Long press: hold high for 20 ticks after the rise → exactly one btn_hold on the 8th tick in STABLE_HIGH, none after. Re-press → btn_hold fires again.
- Reset asserted while btn_level=1 → btn_level=0 at the reset edge, btn_fall stays 0.
- Macro undefined, long press of 20 ticks → btn_hold never asserts; rise/fall timing unchanged.
